riscq_word_packer: RTL and testbench



---
 rtl/riscq_pkg.sv | 24 ++
 rtl/riscq_idle_timer.sv | 46 ++++
 rtl/riscq_word_packer.sv | 166 ++++++++++++++++
 tb/tb_riscq_word_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscq_pkg.sv
// Shared definitions for the riscq host-link loader path.
// Holds the load word width, the section terminator value, the number of
// sections in a complete image and the loader state encoding. riscq_init
// and riscq_word_packer both import this package so they agree on these.
package riscq_pkg;

  localparam int unsigned LOAD_W = 32;
  localparam logic [LOAD_W-1:0] TERM_WORD = 32'hFFFF_FFFF;
  // Instruction section, then data section.
  localparam int unsigned SECTIONS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    DONE
  } riscq_state_e;

  // Returns the byte lane for the next byte of a word. cnt is the number of
  // bytes already held.
  function automatic logic [1:0] byte_lane(input logic [1:0] cnt, input bit big_endian);
    return big_endian ? (2'd3 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/riscq_idle_timer.sv
// Idle counter for a partially assembled word.
// Counts cycles while enabled. A clear (or the enable dropping) zeroes the
// count. o_expire is high in the cycle whose closing edge would take the
// count to TIMEOUT_CYC, so the caller acts on that same edge. A clear in
// that cycle suppresses the expiry.
// TIMEOUT_CYC must be at least 1 and below 2**TO_W.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : zero the count this cycle
//   i_enable       : count this cycle
//   o_expire       : timeout reached on this cycle's edge
module riscq_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign o_expire = i_enable & ~i_clear & (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = '0;
    // The count restarts from zero after an expiry because the owner leaves
    // its counting state on that edge.
    if (i_enable && !i_clear && !o_expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riscq_word_packer.sv
// Host-link front end for riscq_init.
// Assembles the host byte stream into 32-bit load words. Each word is
// presented as a one-cycle o_data/o_data_valid pulse in the cycle after its
// fourth byte. The packer counts 0xFFFFFFFF section terminators. After the
// second terminator it stops accepting bytes until i_clear or reset. A
// partial word that stays idle for TIMEOUT_CYC cycles is dropped, and the
// sticky o_timeout_err flag is set.
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_clear                 : restart for the next image; same effect as reset
//   i_byte, i_byte_valid    : byte stream, no backpressure
//   o_data, o_data_valid    : assembled word (held) and its one-cycle strobe
//   o_byte_cnt              : bytes held in the partial word
//   o_term_cnt              : terminators emitted (saturates at 2)
//   o_load_done             : image complete
//   o_timeout_err           : sticky partial-word discard flag
module riscq_word_packer
  import riscq_pkg::*;
#(
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic [LOAD_W-1:0] o_data,
  output logic              o_data_valid,
  output logic [1:0]        o_byte_cnt,
  output logic [1:0]        o_term_cnt,
  output logic              o_load_done,
  output logic              o_timeout_err
);

  localparam logic [1:0] TERM_LAST = 2'(SECTIONS - 1);
  localparam logic [1:0] TERM_MAX  = 2'(SECTIONS);

  riscq_state_e      state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [LOAD_W-1:0] word_q, word_d;
  logic [LOAD_W-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic [1:0]        term_cnt_q, term_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [1:0]        lane;
  logic [LOAD_W-1:0] merged;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expire;

  // Any valid byte restarts the idle window, even in the expiry cycle.
  assign timer_clear = i_clear | i_byte_valid;
  assign timer_en    = (state_q == ASSEMBLE);

  riscq_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (timer_clear),
    .i_enable (timer_en),
    .o_expire (timer_expire)
  );

  // Partial word with the incoming byte dropped into its lane.
  always_comb begin
    lane   = byte_lane(byte_cnt_q, BIG_ENDIAN);
    merged = (state_q == IDLE) ? '0 : word_q;
    merged[{lane, 3'b000} +: 8] = i_byte;
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    term_cnt_d    = term_cnt_q;
    timeout_err_d = timeout_err_q;

    if (i_clear) begin
      // A byte that arrives in the same cycle as i_clear is dropped.
      state_d       = IDLE;
      byte_cnt_d    = '0;
      word_d        = '0;
      data_d        = '0;
      term_cnt_d    = '0;
      timeout_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_byte_valid) begin
            word_d     = merged;
            byte_cnt_d = 2'd1;
            state_d    = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (i_byte_valid) begin
            if (byte_cnt_q == 2'd3) begin
              data_d       = merged;
              data_valid_d = 1'b1;
              word_d       = '0;
              byte_cnt_d   = '0;
              state_d      = IDLE;
              // The terminator is still emitted; it is also counted here.
              if (merged == TERM_WORD && term_cnt_q < TERM_MAX) begin
                term_cnt_d = term_cnt_q + 2'd1;
                if (term_cnt_q == TERM_LAST) begin
                  state_d = DONE;
                end
              end
            end else begin
              word_d     = merged;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else if (timer_expire) begin
            // Drop the partial word. o_data keeps the last good word.
            word_d        = '0;
            byte_cnt_d    = '0;
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end
        end
        DONE: begin
          // Image complete. Ignore traffic until a restart.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      term_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      term_cnt_q    <= term_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = data_valid_q;
  assign o_byte_cnt    = byte_cnt_q;
  assign o_term_cnt    = term_cnt_q;
  assign o_load_done   = (state_q == DONE);
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_riscq_word_packer.sv
// Testbench for riscq_word_packer.
// A little-endian and a big-endian instance share one input stream. Both
// are checked every cycle against a queue-based model of the packing,
// terminator and timeout rules.
module tb_riscq_word_packer;

  localparam int unsigned TO   = 20;
  localparam int unsigned TO_W = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic [31:0] le_data, be_data;
  logic        le_valid, be_valid;
  logic [1:0]  le_bcnt, be_bcnt, le_term, be_term;
  logic        le_done, be_done, le_err, be_err;

  always #5 clk = ~clk;

  riscq_word_packer #(
    .BIG_ENDIAN  (1'b0),
    .TIMEOUT_CYC (TO),
    .TO_W        (TO_W)
  ) u_dut_le (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_byte        (byte_in),
    .i_byte_valid  (byte_valid),
    .o_data        (le_data),
    .o_data_valid  (le_valid),
    .o_byte_cnt    (le_bcnt),
    .o_term_cnt    (le_term),
    .o_load_done   (le_done),
    .o_timeout_err (le_err)
  );

  riscq_word_packer #(
    .BIG_ENDIAN  (1'b1),
    .TIMEOUT_CYC (TO),
    .TO_W        (TO_W)
  ) u_dut_be (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_byte        (byte_in),
    .i_byte_valid  (byte_valid),
    .o_data        (be_data),
    .o_data_valid  (be_valid),
    .o_byte_cnt    (be_bcnt),
    .o_term_cnt    (be_term),
    .o_load_done   (be_done),
    .o_timeout_err (be_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;

  // Reference model state.
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  int          m_term = 0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_le = '0;
  logic [31:0] m_be = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model(input logic v, input logic [7:0] b, input logic clr, input logic rst);
    m_valid = 1'b0;
    if (!rst || clr) begin
      m_part.delete();
      m_idle = 0;
      m_term = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_le   = '0;
      m_be   = '0;
    end else if (!m_done) begin
      if (v) begin
        m_part.push_back(b);
        m_idle = 0;
        if (m_part.size() == 4) begin
          m_le = '0;
          m_be = '0;
          for (int i = 0; i < 4; i++) begin
            m_le = m_le + (32'(m_part[i]) << (8 * i));
            m_be = m_be + (32'(m_part[i]) << (8 * (3 - i)));
          end
          m_valid = 1'b1;
          m_part.delete();
          if (m_le == 32'hFFFF_FFFF) begin
            m_term++;
            if (m_term == 2) m_done = 1'b1;
          end
        end
      end else if (m_part.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_part.delete();
          m_idle = 0;
          m_err  = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("le_valid", 32'(le_valid), 32'(m_valid));
    check("be_valid", 32'(be_valid), 32'(m_valid));
    check("le_data", le_data, m_le);
    check("be_data", be_data, m_be);
    check("le_byte_cnt", 32'(le_bcnt), 32'(m_part.size()));
    check("be_byte_cnt", 32'(be_bcnt), 32'(m_part.size()));
    check("le_term_cnt", 32'(le_term), 32'(m_term));
    check("be_term_cnt", 32'(be_term), 32'(m_term));
    check("le_load_done", 32'(le_done), 32'(m_done));
    check("be_load_done", 32'(be_done), 32'(m_done));
    check("le_timeout_err", 32'(le_err), 32'(m_err));
    check("be_timeout_err", 32'(be_err), 32'(m_err));
  endtask

  // Drive one cycle, advance the model over the same edge, compare.
  task automatic step(input logic v, input logic [7:0] b, input logic clr, input logic rst);
    byte_valid = v;
    byte_in    = b;
    clear      = clr;
    rst_n      = rst;
    @(posedge clk);
    #1;
    model(v, b, clr, rst);
    if (le_valid) strobes++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      idle(g);
      step(1'b1, w[8*i +: 8], 1'b0, 1'b1);
    end
  endtask

  initial begin
    int base;
    int op;

    rst_n      = 1'b0;
    clear      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_data", le_data, 32'h0);
    idle(2);

    // Packing in both byte orders.
    send_word(32'h0403_0201, 0);
    check("pack_le", le_data, 32'h0403_0201);
    check("pack_be", be_data, 32'h0102_0304);
    check("pack_strobe", 32'(le_valid), 32'd1);
    idle(1);
    check("strobe_one_cycle", 32'(le_valid), 32'd0);

    // Timeout discards a partial word without a strobe.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    idle(TO);
    check("timeout_err", 32'(le_err), 32'd1);
    check("timeout_bcnt", 32'(le_bcnt), 32'd0);
    check("timeout_keeps_data", le_data, 32'h0403_0201);
    send_word(32'hDDCC_BBAA, 0);
    check("after_timeout_word", le_data, 32'hDDCC_BBAA);

    // A byte in the expiry cycle wins over the timeout.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h31, 1'b0, 1'b1);
    idle(TO - 1);
    step(1'b1, 8'h32, 1'b0, 1'b1);
    check("expiry_byte_err", 32'(le_err), 32'd0);
    check("expiry_byte_bcnt", 32'(le_bcnt), 32'd2);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h34, 1'b0, 1'b1);
    check("expiry_word", le_data, 32'h3433_3231);

    // Full image: two sections, each closed by a terminator.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    base = strobes;
    for (int w = 0; w < 32; w++) send_word(32'(w), 2);
    send_word(32'hFFFF_FFFF, 2);
    check("term_after_33", 32'(le_term), 32'd1);
    check("done_after_33", 32'(le_done), 32'd0);
    for (int w = 0; w < 32; w++) send_word(32'h100 + 32'(w), 2);
    send_word(32'hFFFF_FFFF, 0);
    check("term_after_66", 32'(le_term), 32'd2);
    check("done_with_66th", 32'(le_done), 32'd1);
    check("image_strobes", 32'(strobes - base), 32'd66);
    send_word(32'h1234_5678, 0);
    idle(2);
    check("done_ignores_bytes", 32'(strobes - base), 32'd66);

    // Restart from DONE; the byte alongside i_clear is dropped.
    step(1'b1, 8'h55, 1'b1, 1'b1);
    check("clear_term", 32'(le_term), 32'd0);
    check("clear_bcnt", 32'(le_bcnt), 32'd0);
    send_word(32'h0D0C_0B0A, 0);
    check("clear_fresh_word", le_data, 32'h0D0C_0B0A);

    // Reset in the middle of a word.
    step(1'b1, 8'h61, 1'b0, 1'b1);
    step(1'b1, 8'h62, 1'b0, 1'b1);
    step(1'b1, 8'h63, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("midreset_bcnt", 32'(le_bcnt), 32'd0);
    check("midreset_data", le_data, 32'h0);
    send_word(32'h7766_5544, 0);
    check("midreset_word", le_data, 32'h7766_5544);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 19));
      case (op)
        0: step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b1);
        1: step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
        2: idle(int'(TO) - 1 + int'($urandom_range(0, 2)));
        3, 4, 5: send_word(32'hFFFF_FFFF, int'($urandom_range(0, 1)));
        6: idle(int'($urandom_range(1, 3)));
        default: step(1'b1, 8'($urandom), 1'b0, 1'b1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
